// File: rtl/fft4_pkg.sv
// Shared constants and helpers for the 4-point streaming FFT: growth bits, saturation
// and complex pack/unpack on {re, im} words of configurable component width.
package fft4_pkg;

  localparam int GROWTH = 2;

  typedef enum logic {
    MODE_FWD = 1'b0,
    MODE_INV = 1'b1
  } fft_mode_e;

  function automatic logic signed [31:0] sat_dw(input logic signed [31:0] v, input int unsigned dw);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (dw - 32'd1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

  // Sign-extend a dw-bit field sitting in the low bits of v
  function automatic logic signed [31:0] sext_dw(input logic [31:0] v, input int unsigned dw);
    return $signed(v << (32'd32 - dw)) >>> (32'd32 - dw);
  endfunction

  function automatic logic signed [31:0] cplx_re(input logic [63:0] d, input int unsigned dw);
    logic [63:0] sh;
    sh = d >> dw;
    return sext_dw(sh[31:0], dw);
  endfunction

  function automatic logic signed [31:0] cplx_im(input logic [63:0] d, input int unsigned dw);
    return sext_dw(d[31:0], dw);
  endfunction

  function automatic logic [63:0] cplx_pack(input logic signed [31:0] re, input logic signed [31:0] im,
                                            input int unsigned dw);
    logic [63:0] m;
    m = (64'd1 << dw) - 64'd1;
    return (({32'd0, re} & m) << dw) | ({32'd0, im} & m);
  endfunction

endpackage

// File: rtl/fft4_bfly.sv
// Combinational 4-point radix-4 kernel: forward/inverse, per-frame right shift, saturation.
module fft4_bfly
  import fft4_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [3:0][2*DW-1:0] i_x,
  input  fft_mode_e            i_mode,
  input  logic [1:0]           i_scale,
  output logic [3:0][2*DW-1:0] o_y
);

  // 32-bit intermediates hold the DW+GROWTH result exactly for any DW up to 29
  logic signed [31:0] w_re [4];
  logic signed [31:0] w_im [4];
  logic signed [31:0] w_xr [4];
  logic signed [31:0] w_xi [4];
  logic signed [31:0] w_t0r, w_t0i, w_t1r, w_t1i;
  logic [63:0]        w_pk [4];

  // Butterfly arithmetic followed by scaling and saturation of every component
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_re[n] = cplx_re(64'(i_x[n]), DW);
      w_im[n] = cplx_im(64'(i_x[n]), DW);
    end
    w_t0r = w_re[0] - w_re[2];
    w_t0i = w_im[0] - w_im[2];
    w_t1r = w_re[1] - w_re[3];
    w_t1i = w_im[1] - w_im[3];
    w_xr[0] = w_re[0] + w_re[1] + w_re[2] + w_re[3];
    w_xi[0] = w_im[0] + w_im[1] + w_im[2] + w_im[3];
    w_xr[2] = (w_re[0] + w_re[2]) - (w_re[1] + w_re[3]);
    w_xi[2] = (w_im[0] + w_im[2]) - (w_im[1] + w_im[3]);
    if (i_mode == MODE_INV) begin
      w_xr[1] = w_t0r - w_t1i;
      w_xi[1] = w_t0i + w_t1r;
      w_xr[3] = w_t0r + w_t1i;
      w_xi[3] = w_t0i - w_t1r;
    end else begin
      w_xr[1] = w_t0r + w_t1i;
      w_xi[1] = w_t0i - w_t1r;
      w_xr[3] = w_t0r - w_t1i;
      w_xi[3] = w_t0i + w_t1r;
    end
    for (int k = 0; k < 4; k++) begin
      w_pk[k] = cplx_pack(sat_dw(w_xr[k] >>> i_scale, DW), sat_dw(w_xi[k] >>> i_scale, DW), DW);
      o_y[k]  = w_pk[k][2*DW-1:0];
    end
  end

endmodule

// File: rtl/fft4_stream_cfg.sv
// AXI-Stream 4-point FFT/IFFT with ping-pong input/output frame buffers, per-frame
// config latched on beat 0, and tlast framing checks with a saturating error counter.
module fft4_stream_cfg
  import fft4_pkg::*;
#(
  parameter int DW     = 16,
  parameter int ERR_CW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2*DW-1:0]   s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [2*DW-1:0]   m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  input  logic              cfg_inverse,
  input  logic [1:0]        cfg_scale,
  output logic              frame_err,
  output logic [ERR_CW-1:0] err_count
);

  logic [3:0][2*DW-1:0] r_in_buf;
  logic [1:0]           r_in_idx;
  logic                 r_in_full;
  fft_mode_e            r_mode;
  logic [1:0]           r_scale;
  logic [3:0][2*DW-1:0] r_out_buf;
  logic [1:0]           r_out_idx;
  logic                 r_out_busy;
  logic                 r_frame_err;
  logic [ERR_CW-1:0]    r_err_count;

  logic                 w_m_valid, w_m_hs, w_load, w_s_ready, w_in_hs, w_tlast_bad;
  logic [3:0][2*DW-1:0] w_kern;

  assign w_m_valid   = r_out_busy & ~rst;
  assign w_m_hs      = w_m_valid & m_axis_tready;
  // Next frame may enter the output buffer in the same cycle the last beat leaves it
  assign w_load      = r_in_full & (~r_out_busy | (w_m_hs & (r_out_idx == 2'd3)));
  assign w_s_ready   = ~rst & (~r_in_full | w_load);
  assign w_in_hs     = s_axis_tvalid & w_s_ready;
  assign w_tlast_bad = s_axis_tlast ^ (r_in_idx == 2'd3);

  fft4_bfly #(.DW(DW)) u_bfly (
    .i_x     (r_in_buf),
    .i_mode  (r_mode),
    .i_scale (r_scale),
    .o_y     (w_kern)
  );

  // Input side: beat counter, frame buffer and per-frame configuration
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_idx  <= 2'd0;
      r_in_full <= 1'b0;
      r_mode    <= MODE_FWD;
      r_scale   <= 2'd0;
    end else begin
      if (w_in_hs) begin
        r_in_buf[r_in_idx] <= s_axis_tdata;
        r_in_idx           <= r_in_idx + 2'd1;
        if (r_in_idx == 2'd0) begin
          r_mode  <= fft_mode_e'(cfg_inverse);
          r_scale <= cfg_scale;
        end
      end
      if (w_in_hs && (r_in_idx == 2'd3)) begin
        r_in_full <= 1'b1;
      end else if (w_load) begin
        r_in_full <= 1'b0;
      end
    end
  end

  // Output side: registered kernel result drained in natural order
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_idx  <= 2'd0;
      r_out_busy <= 1'b0;
    end else if (w_load) begin
      r_out_buf  <= w_kern;
      r_out_idx  <= 2'd0;
      r_out_busy <= 1'b1;
    end else if (w_m_hs) begin
      r_out_idx <= r_out_idx + 2'd1;
      if (r_out_idx == 2'd3) begin
        r_out_busy <= 1'b0;
      end
    end
  end

  // Framing check: one-cycle pulse and saturating mismatch count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_frame_err <= w_in_hs & w_tlast_bad;
      if (w_in_hs && w_tlast_bad && (r_err_count != {ERR_CW{1'b1}})) begin
        r_err_count <= r_err_count + ERR_CW'(1);
      end
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tvalid = w_m_valid;
  assign m_axis_tlast  = w_m_valid & (r_out_idx == 2'd3);
  assign m_axis_tdata  = rst ? '0 : r_out_buf[r_out_idx];
  assign frame_err     = r_frame_err & ~rst;
  assign err_count     = rst ? '0 : r_err_count;

endmodule

// File: tb/tb_fft4_stream_cfg.sv
// Randomized self-checking bench: a DFT-sum reference model predicts every output beat,
// framing error pulse and error count; directed frames pin known results.
module tb_fft4_stream_cfg;

  localparam int DW = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tready, s_tlast;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic        cfg_inverse;
  logic [1:0]  cfg_scale;
  logic        frame_err;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rdy_mode = 0;

  logic [32:0] exp_q[$];
  int          m_idx = 0;
  int          m_re[4];
  int          m_im[4];
  bit          m_inv;
  int          m_sc;
  bit          err_pend = 1'b0;
  int          cnt_model = 0;

  bit b2b_on = 1'b0, b2b_loaded = 1'b0;
  int b2b_outs = 0, b2b_first = 0, b2b_last = 0;

  fft4_stream_cfg #(.DW(DW), .ERR_CW(8)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .cfg_inverse(cfg_inverse), .cfg_scale(cfg_scale),
    .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // X[k] = sum x[n] * W^(nk) with W = -j (forward) or +j (inverse), then >>> sc and saturate
  function automatic logic [31:0] dft(input int re[4], input int im[4], input bit inv, input int sc, input int k);
    int sr, si, m, r, i;
    sr = 0; si = 0;
    for (int n = 0; n < 4; n++) begin
      m = inv ? ((n * k) % 4) : ((4 - (n * k) % 4) % 4);
      case (m)
        0: begin r = re[n];  i = im[n];  end
        1: begin r = -im[n]; i = re[n];  end
        2: begin r = -re[n]; i = -im[n]; end
        default: begin r = im[n]; i = -re[n]; end
      endcase
      sr += r; si += i;
    end
    sr = sr >>> sc; si = si >>> sc;
    if (sr > 32767) sr = 32767;
    if (sr < -32768) sr = -32768;
    if (si > 32767) si = 32767;
    if (si < -32768) si = -32768;
    return {16'(sr), 16'(si)};
  endfunction

  function automatic logic [31:0] mk(input int r, input int i);
    return {16'(r), 16'(i)};
  endfunction

  // Reference model and per-cycle comparison, sampled away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_tready", s_tready, 0);
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tlast", m_tlast, 0);
      chk("rst_tdata", m_tdata, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_err_count", err_count, 0);
      exp_q.delete();
      m_idx = 0; err_pend = 1'b0; cnt_model = 0;
    end else begin
      chk("frame_err", frame_err, err_pend);
      chk("err_count", err_count, cnt_model);
      err_pend = 1'b0;
      if (s_tvalid && s_tready) begin
        if (m_idx == 0) begin
          m_inv = cfg_inverse;
          m_sc  = cfg_scale;
        end
        m_re[m_idx] = $signed(s_tdata[31:16]);
        m_im[m_idx] = $signed(s_tdata[15:0]);
        if (s_tlast != (m_idx == 3)) begin
          err_pend = 1'b1;
          if (cnt_model < 255) cnt_model++;
        end
        if (m_idx == 3) begin
          for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), dft(m_re, m_im, m_inv, m_sc, k)});
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      if (b2b_on) begin
        if (b2b_loaded && s_tvalid) chk("b2b_tready", s_tready, 1);
        if (m_tvalid) b2b_loaded = 1'b1;
        if (m_tvalid && m_tready) begin
          if (b2b_outs == 0) b2b_first = cyc;
          b2b_outs++;
          if (b2b_outs == 40) b2b_last = cyc;
        end
      end
      if (exp_q.size() == 0) begin
        chk("idle_tvalid", m_tvalid, 0);
      end else if (m_tvalid) begin
        chk("tdata", m_tdata, exp_q[0][31:0]);
        chk("tlast", m_tlast, exp_q[0][32]);
        if (m_tready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: m_tready = 1'b1;
        1: m_tready = ($urandom % 3) != 0;
        default: m_tready = 1'b0;
      endcase
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic last, input logic inv, input logic [1:0] sc);
    int n;
    n = 0;
    s_tdata = d; s_tlast = last; cfg_inverse = inv; cfg_scale = sc; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", s_tready, 1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] d0, d1, d2, d3, input logic inv, input logic [1:0] sc);
    send_beat(d0, 1'b0, inv, sc);
    send_beat(d1, 1'b0, $urandom, 2'($urandom_range(0, 2)));
    send_beat(d2, 1'b0, $urandom, 2'($urandom_range(0, 2)));
    send_beat(d3, 1'b1, $urandom, 2'($urandom_range(0, 2)));
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    int re[4];
    int im[4];
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; cfg_inverse = 1'b0; cfg_scale = 2'd0;

    re = '{10, 20, 30, 40}; im = '{0, 0, 0, 0};
    chk("pin_fwd_x0", dft(re, im, 1'b0, 0, 0), 32'h0064_0000);
    chk("pin_fwd_x1", dft(re, im, 1'b0, 0, 1), 32'hFFEC_0014);
    chk("pin_fwd_x2", dft(re, im, 1'b0, 0, 2), 32'hFFEC_0000);
    chk("pin_fwd_x3", dft(re, im, 1'b0, 0, 3), 32'hFFEC_FFEC);
    chk("pin_inv_x1", dft(re, im, 1'b1, 0, 1), 32'hFFEC_FFEC);
    chk("pin_inv_x3", dft(re, im, 1'b1, 0, 3), 32'hFFEC_0014);
    chk("pin_sc2_x0", dft(re, im, 1'b0, 2, 0), 32'h0019_0000);
    chk("pin_sc2_x1", dft(re, im, 1'b0, 2, 1), 32'hFFFB_0005);
    re = '{32767, 32767, 32767, 32767};
    chk("pin_sat_hi", dft(re, im, 1'b0, 0, 0), 32'h7FFF_0000);
    chk("pin_sat_x1", dft(re, im, 1'b0, 0, 1), 32'h0000_0000);
    re = '{-32768, -32768, -32768, -32768};
    chk("pin_sat_lo", dft(re, im, 1'b0, 0, 0), 32'h8000_0000);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    rdy_mode = 0;
    send_frame(mk(10, 0), mk(20, 0), mk(30, 0), mk(40, 0), 1'b0, 2'd0);
    send_frame(mk(10, 0), mk(20, 0), mk(30, 0), mk(40, 0), 1'b1, 2'd0);
    send_frame(mk(10, 0), mk(20, 0), mk(30, 0), mk(40, 0), 1'b0, 2'd2);
    send_frame(mk(32767, 0), mk(32767, 0), mk(32767, 0), mk(32767, 0), 1'b0, 2'd0);
    send_frame(mk(-32768, 0), mk(-32768, 0), mk(-32768, 0), mk(-32768, 0), 1'b0, 2'd0);
    wait_drain();

    apply_reset();
    send_beat(mk(1, 2), 1'b0, 1'b0, 2'd0);
    send_beat(mk(3, 4), 1'b1, 1'b0, 2'd0);
    send_beat(mk(5, 6), 1'b0, 1'b0, 2'd0);
    send_beat(mk(7, 8), 1'b1, 1'b0, 2'd0);
    send_beat(mk(-9, 1), 1'b0, 1'b1, 2'd1);
    send_beat(mk(2, -3), 1'b0, 1'b0, 2'd0);
    send_beat(mk(4, 5), 1'b0, 1'b0, 2'd0);
    send_beat(mk(-6, 7), 1'b0, 1'b0, 2'd0);
    wait_drain();
    chk("err_count_two", err_count, 8'd2);

    b2b_on = 1'b1;
    for (int f = 0; f < 10; f++)
      send_frame($urandom, $urandom, $urandom, $urandom, 1'($urandom), 2'($urandom_range(0, 2)));
    wait_drain();
    b2b_on = 1'b0;
    chk("b2b_outputs", b2b_outs, 40);
    chk("b2b_no_bubbles", b2b_last - b2b_first, 39);

    send_beat($urandom, 1'b0, 1'b0, 2'd0);
    send_beat($urandom, 1'b0, 1'b0, 2'd0);
    apply_reset();
    send_frame(mk(10, 0), mk(20, 0), mk(30, 0), mk(40, 0), 1'b0, 2'd0);
    repeat (3) begin @(posedge clk); #1; end
    apply_reset();
    send_frame(mk(100, -50), mk(-20, 7), mk(33, 33), mk(0, -1), 1'b1, 2'd1);
    wait_drain();

    rdy_mode = 1;
    for (int f = 0; f < 30; f++) begin
      for (int b = 0; b < 4; b++) begin
        send_beat($urandom, 1'((b == 3) ^ (($urandom % 12) == 0)), 1'($urandom), 2'($urandom_range(0, 2)));
        repeat ($urandom % 2) begin @(posedge clk); #1; end
      end
    end
    wait_drain();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
